absdiff_serial_ctrl: RTL
========================

// Module: absdiff_serial_ctrl
//
// PURPOSE
//  Bit-serial absolute-difference unit built around a single shared 1-bit
//  greater-than comparator slice (in0, in1, din -> dout, gt) and a 1-bit
//  subtractor slice.
//  A controller FSM does two passes over a latched operand pair:
//   - compare pass: sequences the comparator slice MSB-first, with early exit;
//   - subtract pass: sequences the subtractor slice LSB-first.
//  It then returns |in0-in1| and the in0>in1 flag over val/rdy handshakes.
//  Area-lean alternative to the parallel absdiff datapath.
//
// PARAMETERS
//  nbits  8  operand/result width; must be >= 2
//
// PORTS
//  clk     in   1      clock, all state updates on the rising edge
//  rst     in   1      reset; asynchronous, active-low (0 = reset asserted)
//  in_val  in   1      operand pair valid
//  in_rdy  out  1      unit can accept an operand pair
//  in0     in   nbits  operand A, sampled on accept
//  in1     in   nbits  operand B, sampled on accept
//  out_val out  1      result valid
//  out_rdy in   1      consumer accepts result
//  out     out  nbits  |A-B|
//  out_gt  out  1      1 iff A>B (unsigned)
//
// BEHAVIOUR
//  Reset and port timing
//   - rst=0 immediately forces state IDLE.
//   - Reset clears: A, B, R (result reg), idx, decided, gt, borrow, out=0,
//     out_gt=0, out_val=0. in_rdy=1 whenever in IDLE.
//   - in_rdy and out_val are decoded from state only.
//   - No combinational in->out paths.
//
//  States
//   IDLE  in_rdy=1, out_val=0.
//     - Accept on edge with in_val&in_rdy: A<=in0, B<=in1, idx<=nbits-1,
//       decided<=0, gt<=0 -> CMP.
//   CMP   one slice evaluation per cycle on a=A[idx], b=B[idx], din=decided:
//     - dout = din | (a^b)
//     - gt_n = gt | (~din & a & ~b)
//     - Update decided<=dout and gt<=gt_n.
//     - If dout | (idx==0): idx<=0, borrow<=0 -> SUB. Else idx<=idx-1.
//     - CMP lasts k = 1 + (number of leading equal bits) cycles, capped at
//       nbits.
//   SUB   x = gt ? A[idx] : B[idx]; y = gt ? B[idx] : A[idx]:
//     - R[idx] <= x^y^borrow
//     - borrow <= (~x&y) | (~(x^y)&borrow)
//     - idx++. After bit nbits-1 -> DONE.
//     - Exactly nbits cycles. Final borrow is always 0, since the larger
//       operand is the minuend.
//   DONE  out_val=1, out=R, out_gt=gt, all held stable while out_rdy=0.
//     - On edge with out_rdy=1 -> IDLE.
//     - in_rdy=0; there is no same-cycle bypass to a new accept.
//
//  Latency and boundary cases
//   - Latency: out_val rises k+nbits edges after the accept edge.
//     Throughput: one op per k+nbits+1 cycles minimum.
//   - in_val while not IDLE: ignored; in0/in1 changes after accept have no
//     effect.
//   - A==B: CMP runs all nbits cycles, gt=0, out=0.
//   - out/out_gt outside DONE: hold their last values and are don't-care;
//     they are cleared only by reset.
//   - Reset mid-CMP/SUB/DONE: the transaction is discarded; the next
//     transaction after reset release computes correctly.
//
// TESTING  (nbits=8; "edge N" counted from the accept edge)
//  1. in0=0x05, in1=0x03
//     -> k=6; out_val at edge 14; out=0x02, out_gt=1.
//  2. in0=0x10, in1=0xF0
//     -> k=1 (decided at bit 7); out_val at edge 9; out=0xE0, out_gt=0.
//  3. in0=in1=0xA5
//     -> k=8; out_val at edge 16; out=0x00, out_gt=0.
//  4. in0=0xFF, in1=0x00 -> out=0xFF, out_gt=1;
//     then in0=0x00, in1=0xFF -> out=0xFF, out_gt=0.
//  5. Hold out_rdy=0 for 5 cycles in DONE while pulsing in_val with new data
//     -> out_val=1 and out/out_gt stable, in_rdy=0, pulses ignored;
//     out_rdy=1 -> IDLE on the next edge, in_rdy=1.
//  6. Drive rst=0 mid-SUB of 0x80 vs 0x01
//     -> out_val=0 and in_rdy=1 without waiting for a clock edge;
//     after release, 0x80 vs 0x01 -> out=0x7F, out_gt=1.

Source files
------------

// File: rtl/absdiff_serial_ctrl.sv
// ---------------------------------------------------------------------------
// absdiff_serial_ctrl
//
// Bit-serial absolute-difference unit. One shared 1-bit greater-than slice is
// stepped MSB-first over a latched operand pair (stopping at the first
// differing bit). One 1-bit subtractor slice is then stepped LSB-first, with
// the larger operand as minuend. |A-B| and the A>B flag are returned over a
// val/rdy handshake.
//
// Handshake: a transfer happens on a rising clk edge where both val and rdy
// are 1. in_rdy and out_val are decoded from the FSM state only, so neither
// depends combinationally on any input. out/out_gt are held stable while
// out_val=1.
//
// Ports
//   clk         in   1      rising-edge clock
//   rst         in   1      asynchronous, active-low reset
//   in_val      in   1      operand pair valid
//   in_rdy      out  1      unit idle, can accept an operand pair
//   in0         in   nbits  operand A, sampled on accept
//   in1         in   nbits  operand B, sampled on accept
//   out_val     out  1      result valid
//   out_rdy     in   1      consumer accepts result
//   out         out  nbits  |A-B|
//   out_gt      out  1      1 iff A>B (unsigned)
//   o_dbg_state out  2      current FSM state (IDLE=0, CMP=1, SUB=2, DONE=3)
// ---------------------------------------------------------------------------
module absdiff_serial_ctrl #(
    parameter int nbits = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [nbits-1:0] in0,
    input  logic [nbits-1:0] in1,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [nbits-1:0] out,
    output logic             out_gt,
    output logic [1:0]       o_dbg_state
);

    localparam int IW = $clog2(nbits);
    localparam logic [IW-1:0] LAST = IW'(nbits - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        SUB  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_n;

    logic [nbits-1:0] r_a;
    logic [nbits-1:0] r_b;
    logic [nbits-1:0] r_res;
    logic [IW-1:0]    r_idx;
    logic             r_decided;
    logic             r_gt;
    logic             r_borrow;
    logic [nbits-1:0] r_out;
    logic             r_out_gt;

    // Shared slice inputs: the current bit of each operand.
    logic             w_a;
    logic             w_b;
    // Comparator slice.
    logic             w_dout;
    logic             w_gt_n;
    logic             w_cmp_done;
    // Subtractor slice.
    logic             w_x;
    logic             w_y;
    logic             w_diff;
    logic             w_borrow_n;
    logic [nbits-1:0] w_res_n;
    logic             w_sub_last;

    assign w_a = r_a[r_idx];
    assign w_b = r_b[r_idx];

    // din is the "already decided" flag; once a differing bit is seen the
    // lower bits cannot change the verdict.
    assign w_dout     = r_decided | (w_a ^ w_b);
    assign w_gt_n     = r_gt | (~r_decided & w_a & ~w_b);
    assign w_cmp_done = w_dout | (r_idx == '0);

    // Larger operand is the minuend, so the final borrow is always zero.
    assign w_x        = r_gt ? w_a : w_b;
    assign w_y        = r_gt ? w_b : w_a;
    assign w_diff     = w_x ^ w_y ^ r_borrow;
    assign w_borrow_n = (~w_x & w_y) | (~(w_x ^ w_y) & r_borrow);
    assign w_sub_last = (r_idx == LAST);

    always_comb begin
        w_res_n        = r_res;
        w_res_n[r_idx] = w_diff;
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            IDLE: if (in_val)     w_state_n = CMP;
            CMP:  if (w_cmp_done) w_state_n = SUB;
            SUB:  if (w_sub_last) w_state_n = DONE;
            DONE: if (out_rdy)    w_state_n = IDLE;
            default:              w_state_n = IDLE;
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_idx     <= '0;
            r_decided <= 1'b0;
            r_gt      <= 1'b0;
            r_borrow  <= 1'b0;
            r_out     <= '0;
            r_out_gt  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_val) begin
                        r_a       <= in0;
                        r_b       <= in1;
                        r_idx     <= LAST;
                        r_decided <= 1'b0;
                        r_gt      <= 1'b0;
                    end
                end
                CMP: begin
                    r_decided <= w_dout;
                    r_gt      <= w_gt_n;
                    if (w_cmp_done) begin
                        r_idx    <= '0;
                        r_borrow <= 1'b0;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                SUB: begin
                    r_res    <= w_res_n;
                    r_borrow <= w_borrow_n;
                    if (w_sub_last) begin
                        // Capture the finished result so out/out_gt stay
                        // frozen until the next transaction completes.
                        r_out    <= w_res_n;
                        r_out_gt <= r_gt;
                        r_idx    <= '0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_rdy      = (r_state == IDLE);
    assign out_val     = (r_state == DONE);
    assign out         = r_out;
    assign out_gt      = r_out_gt;
    assign o_dbg_state = r_state;

endmodule
